ysyx_22050710_ifu: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the decode unit (idu).

---
 rtl/ysyx_22050710_ifu.sv | 128 ++++++++++++
 tb/tb_ysyx_22050710_ifu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: single-outstanding imem requester feeding a small
// {pc, inst} FIFO toward decode, flushed by execute redirects.
`default_nettype none

module ysyx_22050710_ifu #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [63:0] o_pc,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_f_q, pc_f_d;
  logic [63:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];

  logic req_hs, push, pop, fifo_nonempty;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  assign fifo_nonempty    = (count_q != '0);
  assign o_imem_req_valid = (state_q == S_REQ) && (count_q < DEPTH_C) && !i_rst;
  assign o_imem_req_addr  = pc_f_q;
  assign req_hs           = o_imem_req_valid && i_imem_req_ready;

  // A redirect flushes the FIFO, so it also cancels any same-cycle push or pop.
  assign push = (state_q == S_WAIT) && i_imem_resp_valid && !i_redirect;
  assign pop  = fifo_nonempty && i_inst_ready && !i_redirect;

  assign o_inst_valid = fifo_nonempty;
  assign o_inst       = fifo_nonempty ? buf_inst_q[rd_ptr_q] : NOP;
  assign o_pc         = fifo_nonempty ? buf_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d  = i_redirect ? S_DROP : S_WAIT;
          pc_f_d   = pc_f_q + 64'd4;
          req_pc_d = pc_f_q;
        end
      end
      S_WAIT: begin
        if (i_imem_resp_valid) state_d = S_REQ;
        else if (i_redirect)   state_d = S_DROP;
      end
      S_DROP: begin
        if (i_imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (i_redirect) pc_f_d = {i_redirect_pc[63:2], 2'b00};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_REQ;
      pc_f_q   <= RESET_PC;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
      buf_inst_q[wr_ptr_q] <= i_imem_resp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_ifu.sv
// Scoreboard bench for ysyx_22050710_ifu: directed scenarios push expected
// request addresses and delivered {pc, inst} pairs; a monitor pops and compares.
module tb_ysyx_22050710_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [63:0] exp_req[$];
  logic [95:0] exp_inst[$];

  int unsigned resp_delay = 1;
  logic        flush_resp = 1'b0;
  logic        pend = 1'b0;
  int unsigned pend_cnt = 0;
  logic [63:0] pend_addr = '0;

  ysyx_22050710_ifu #(
    .RESET_PC (64'h0000_0000_8000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_resp_valid(resp_valid),
    .i_imem_resp_data (resp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_pc             (pc),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // imem model (data = {16'hC0DE, addr[15:0]}) plus scoreboard monitor
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_req: got addr %h, want no request", req_addr);
        end else begin
          chk("req_addr", req_addr, exp_req.pop_front());
        end
        pend = 1'b1; pend_cnt = resp_delay; pend_addr = req_addr;
      end else if (flush_resp) begin
        pend = 1'b0;
      end
      if (!rst && inst_valid && inst_ready && !redirect) begin
        if (exp_inst.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_pop: got pc %h inst %h, want no delivery", pc, inst);
        end else begin
          e = exp_inst.pop_front();
          chk("inst_pc", pc, e[95:32]);
          chk("inst_word", {32'h0, inst}, {32'h0, e[31:0]});
        end
      end
      @(posedge clk); #1;
      resp_valid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = {16'hC0DE, pend_addr[15:0]};
          pend = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic run_until_hs(input int unsigned n, input string name);
    int unsigned seen = 0;
    int unsigned cyc = 0;
    while (seen < n && cyc < 64) begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) seen++;
      cyc++;
      step();
    end
    vectors++;
    if (seen < n) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d handshakes, want %0d", name, seen, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; flush_resp = 1'b1; resp_delay = 1;
    step(); step();
    @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_addr", req_addr, 64'h0000_0000_8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_nop", 64'(inst), 64'h13);
    chk("rst_pc_zero", pc, 64'd0);
    step();
    rst = 1'b0; flush_resp = 1'b0;
  endtask

  task automatic end_test(input string name);
    chk({name, "_req_q_empty"}, 64'(exp_req.size()), 64'd0);
    chk({name, "_inst_q_empty"}, 64'(exp_inst.size()), 64'd0);
    exp_req.delete();
    exp_inst.delete();
  endtask

  initial begin
    // 1: streaming fetch from reset
    do_reset();
    exp_req = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    exp_inst = '{{64'h8000_0000, 32'hC0DE_0000}, {64'h8000_0004, 32'hC0DE_0004},
                 {64'h8000_0008, 32'hC0DE_0008}};
    req_ready = 1'b1; inst_ready = 1'b1;
    run_until_hs(3, "t1");
    req_ready = 1'b0;
    idle(4);
    end_test("t1");

    // 2: backpressure fills FIFO, one pop frees exactly one request
    do_reset();
    exp_req = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    req_ready = 1'b1;
    run_until_hs(2, "t2");
    idle(3);
    @(negedge clk);
    chk("t2_full_req_valid", 64'(req_valid), 64'd0);
    chk("t2_full_head_pc", pc, 64'h8000_0000);
    exp_inst.push_back({64'h8000_0000, 32'hC0DE_0000});
    step(); inst_ready = 1'b1;
    step(); inst_ready = 1'b0;
    idle(6);
    @(negedge clk);
    chk("t2_refull_req_valid", 64'(req_valid), 64'd0);
    chk("t2_head_pc", pc, 64'h8000_0004);
    chk("t2_head_inst", 64'(inst), 64'hC0DE_0004);
    step();
    end_test("t2");

    // 3: redirect while waiting drops the in-flight response
    do_reset();
    exp_req.push_back(64'h8000_0000);
    resp_delay = 3; req_ready = 1'b1; inst_ready = 1'b1;
    run_until_hs(1, "t3a");
    redirect = 1'b1; redirect_pc = 64'h8000_1002;
    step();
    redirect = 1'b0; resp_delay = 1;
    exp_req.push_back(64'h8000_1000);
    exp_inst.push_back({64'h8000_1000, 32'hC0DE_1000});
    @(negedge clk);
    chk("t3_drop_req_valid", 64'(req_valid), 64'd0);
    run_until_hs(1, "t3b");
    req_ready = 1'b0;
    idle(4);
    end_test("t3");

    // 4: redirect coincident with response and with a pop of the buffered entry
    do_reset();
    exp_req = '{64'h8000_0000, 64'h8000_0004};
    resp_delay = 2; req_ready = 1'b1;
    run_until_hs(2, "t4");
    step();
    redirect = 1'b1; redirect_pc = 64'h8000_2000; inst_ready = 1'b1;
    step();
    redirect = 1'b0; resp_delay = 1;
    exp_req.push_back(64'h8000_2000);
    exp_inst.push_back({64'h8000_2000, 32'hC0DE_2000});
    @(negedge clk);
    chk("t4_flushed_valid", 64'(inst_valid), 64'd0);
    chk("t4_flushed_nop", 64'(inst), 64'h13);
    chk("t4_flushed_pc", pc, 64'd0);
    chk("t4_new_req_valid", 64'(req_valid), 64'd1);
    step();
    req_ready = 1'b0;
    idle(4);
    end_test("t4");

    // 5: request held stable under ready=0, no bypass on response
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(req_valid), 64'd1);
      chk("t5_hold_addr", req_addr, 64'h8000_0000);
      step();
    end
    exp_req.push_back(64'h8000_0000);
    exp_inst.push_back({64'h8000_0000, 32'hC0DE_0000});
    req_ready = 1'b1;
    run_until_hs(1, "t5");
    req_ready = 1'b0;
    @(negedge clk);
    chk("t5_no_bypass", 64'(inst_valid), 64'd0);
    idle(4);
    end_test("t5");

    // 6: reset while waiting; the late response must not be pushed
    do_reset();
    exp_req = '{64'h8000_0000, 64'h8000_0004};
    req_ready = 1'b1;
    run_until_hs(1, "t6a");
    resp_delay = 4;
    run_until_hs(1, "t6b");
    rst = 1'b1; req_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(req_valid), 64'd1);
    chk("t6_rst_req_addr", req_addr, 64'h8000_0000);
    idle(4);
    @(negedge clk);
    chk("t6_stale_ignored", 64'(inst_valid), 64'd0);
    chk("t6_stale_pc", pc, 64'd0);
    step();
    resp_delay = 1; inst_ready = 1'b1;
    exp_req.push_back(64'h8000_0000);
    exp_inst.push_back({64'h8000_0000, 32'hC0DE_0000});
    req_ready = 1'b1;
    run_until_hs(1, "t6c");
    req_ready = 1'b0;
    idle(4);
    end_test("t6");

    // 7: redirect on a handshake cycle, target alignment and pc wrap at 2^64
    do_reset();
    exp_req = '{64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    exp_inst = '{{64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DE_FFFC}, {64'h0, 32'hC0DE_0000}};
    req_ready = 1'b1; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect = 1'b0;
    run_until_hs(2, "t7");
    req_ready = 1'b0;
    idle(4);
    end_test("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
